// File: rtl/shift_arb_if.sv
// Request/response bundle between the two shift requesters, the result consumer
// and shift_arb. The arbiter side is the slave modport.
interface shift_arb_if;
    logic        req0;
    logic [31:0] d0;
    logic [4:0]  sa0;
    logic        right0;
    logic        arith0;
    logic        ack0;
    logic        req1;
    logic [31:0] d1;
    logic [4:0]  sa1;
    logic        right1;
    logic        arith1;
    logic        ack1;
    logic [31:0] res;
    logic        res_id;
    logic        res_valid;
    logic        res_ready;

    modport master (
        output req0, d0, sa0, right0, arith0,
        output req1, d1, sa1, right1, arith1,
        output res_ready,
        input  ack0, ack1, res, res_id, res_valid
    );

    modport slave (
        input  req0, d0, sa0, right0, arith0,
        input  req1, d1, sa1, right1, arith1,
        input  res_ready,
        output ack0, ack1, res, res_id, res_valid
    );
endinterface

// File: rtl/shift_arb.sv
// Two-port arbiter in front of the shared 32-bit barrel shifter: operand register,
// shifter, result register, with valid/ready backpressure on the result.
module shift_arb #(
    parameter bit ARB_RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    shift_arb_if.slave  bus
);

    function automatic logic [31:0] shift_mux(input logic [31:0] d, input logic [4:0] sa,
                                              input logic right, input logic arith);
        logic [31:0] r;
        if (!right)
            r = d << sa;
        else if (arith)
            r = $signed(d) >>> sa;
        else
            r = d >> sa;
        return r;
    endfunction

    logic        v1_q, v1_d;
    logic [31:0] op_d_q, op_d_d;
    logic [4:0]  op_sa_q, op_sa_d;
    logic        op_right_q, op_right_d;
    logic        op_arith_q, op_arith_d;
    logic        op_id_q, op_id_d;
    logic        v2_q, v2_d;
    logic [31:0] res_q, res_d;
    logic        res_id_q, res_id_d;
    logic        last_q, last_d;

    logic adv1, adv2;
    logic gnt_vld, gnt_id;

    assign adv2 = !v2_q || bus.res_ready;
    assign adv1 = !v1_q || adv2;

    // A grant is only issued when stage 1 can take it, so every ack is a transfer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!rst && adv1) begin
            if (bus.req0 && bus.req1) begin
                gnt_vld = 1'b1;
                gnt_id  = ARB_RR ? !last_q : 1'b0;
            end else if (bus.req0) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (bus.req1) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign bus.ack0 = gnt_vld && !gnt_id;
    assign bus.ack1 = gnt_vld && gnt_id;

    always_comb begin
        v1_d       = v1_q;
        op_d_d     = op_d_q;
        op_sa_d    = op_sa_q;
        op_right_d = op_right_q;
        op_arith_d = op_arith_q;
        op_id_d    = op_id_q;
        v2_d       = v2_q;
        res_d      = res_q;
        res_id_d   = res_id_q;
        last_d     = last_q;

        if (adv1) begin
            v1_d = gnt_vld;
            if (gnt_vld) begin
                op_d_d     = gnt_id ? bus.d1     : bus.d0;
                op_sa_d    = gnt_id ? bus.sa1    : bus.sa0;
                op_right_d = gnt_id ? bus.right1 : bus.right0;
                op_arith_d = gnt_id ? bus.arith1 : bus.arith0;
                op_id_d    = gnt_id;
                last_d     = gnt_id;
            end
        end

        // An empty stage 1 leaves the last result visible in the output register.
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                res_d    = shift_mux(op_d_q, op_sa_q, op_right_q, op_arith_q);
                res_id_d = op_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            op_d_q     <= 32'h0;
            op_sa_q    <= 5'h0;
            op_right_q <= 1'b0;
            op_arith_q <= 1'b0;
            op_id_q    <= 1'b0;
            v2_q       <= 1'b0;
            res_q      <= 32'h0;
            res_id_q   <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            v1_q       <= v1_d;
            op_d_q     <= op_d_d;
            op_sa_q    <= op_sa_d;
            op_right_q <= op_right_d;
            op_arith_q <= op_arith_d;
            op_id_q    <= op_id_d;
            v2_q       <= v2_d;
            res_q      <= res_d;
            res_id_q   <= res_id_d;
            last_q     <= last_d;
        end
    end

    assign bus.res       = res_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = v2_q;

endmodule

// File: tb/tb_shift_arb.sv
// Directed-vector bench for shift_arb: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_shift_arb;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    shift_arb_if rr ();
    shift_arb_if fp ();

    shift_arb #(.ARB_RR(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(rr));
    shift_arb #(.ARB_RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(fp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  sw_sa  [4] = '{5'd31, 5'd31, 5'd31, 5'd0};
    logic        sw_r   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        sw_a   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] sw_exp [4] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0001};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_ports();
        rr.req0 = 1'b0; rr.d0 = 32'h0; rr.sa0 = 5'd0; rr.right0 = 1'b0; rr.arith0 = 1'b0;
        rr.req1 = 1'b0; rr.d1 = 32'h0; rr.sa1 = 5'd0; rr.right1 = 1'b0; rr.arith1 = 1'b0;
        fp.req0 = 1'b0; fp.d0 = 32'h0; fp.sa0 = 5'd0; fp.right0 = 1'b0; fp.arith0 = 1'b0;
        fp.req1 = 1'b0; fp.d1 = 32'h0; fp.sa1 = 5'd0; fp.right1 = 1'b0; fp.arith1 = 1'b0;
    endtask

    initial begin
        int k;
        n_vec = 0;
        n_err = 0;
        idle_ports();
        rr.res_ready = 1'b1;
        fp.res_ready = 1'b1;
        rst = 1'b1;

        // Reset state, with a request pending to show acks are held low.
        rr.req0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(rr.res_valid), 0);
        chk("rst_res",   rr.res,            32'h0);
        chk("rst_id",    32'(rr.res_id),    0);
        chk("rst_ack0",  32'(rr.ack0),      0);

        // First op: arithmetic right shift by 4.
        rst = 1'b0;
        rr.d0 = 32'h8000_00F0; rr.sa0 = 5'd4; rr.right0 = 1'b1; rr.arith0 = 1'b1;
        #1;
        chk("t1_ack0", 32'(rr.ack0), 1);
        chk("t1_ack1", 32'(rr.ack1), 0);
        cyc();
        rr.req0 = 1'b0;
        #1;
        chk("t1_val_e1", 32'(rr.res_valid), 0);
        cyc();
        #1;
        chk("t1_val", 32'(rr.res_valid), 1);
        chk("t1_res", rr.res,            32'hF800_000F);
        chk("t1_id",  32'(rr.res_id),    0);
        cyc();
        #1;
        chk("t1_val_once", 32'(rr.res_valid), 0);

        // Mode sweep, back-to-back on port 0.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                rr.req0 = 1'b1; rr.d0 = 32'h8000_0001; rr.sa0 = sw_sa[i];
                rr.right0 = sw_r[i]; rr.arith0 = sw_a[i];
            end else begin
                rr.req0 = 1'b0;
            end
            #1;
            if (i < 4) chk($sformatf("sw_ack%0d", i), 32'(rr.ack0), 1);
            if (i >= 2) begin
                chk($sformatf("sw_val%0d", i - 2), 32'(rr.res_valid), 1);
                chk($sformatf("sw_res%0d", i - 2), rr.res, sw_exp[i - 2]);
            end
            cyc();
        end
        #1;
        chk("sw_drained", 32'(rr.res_valid), 0);

        // Solo port 1 op, left by 8; leaves last = 1.
        rr.req1 = 1'b1; rr.d1 = 32'h0000_00FF; rr.sa1 = 5'd8; rr.right1 = 1'b0; rr.arith1 = 1'b0;
        #1;
        chk("p1_ack1", 32'(rr.ack1), 1);
        chk("p1_ack0", 32'(rr.ack0), 0);
        cyc();
        rr.req1 = 1'b0;
        cyc();
        #1;
        chk("p1_res", rr.res,         32'h0000_FF00);
        chk("p1_id",  32'(rr.res_id), 1);
        cyc();

        // Contested round-robin: acks alternate starting with port 0.
        rr.d0 = 32'h1111_0000; rr.sa0 = 5'd0; rr.right0 = 1'b0;
        rr.d1 = 32'h2222_0000; rr.sa1 = 5'd0; rr.right1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rr.req0 = (i < 4);
            rr.req1 = (i < 4);
            #1;
            if (i < 4) begin
                chk($sformatf("rr_ack0_%0d", i), 32'(rr.ack0), 32'(i % 2 == 0));
                chk($sformatf("rr_ack1_%0d", i), 32'(rr.ack1), 32'(i % 2 == 1));
            end
            if (i >= 2) begin
                chk($sformatf("rr_id%0d", i - 2), 32'(rr.res_id), 32'((i - 2) % 2));
                chk($sformatf("rr_res%0d", i - 2), rr.res,
                    ((i - 2) % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000);
            end
            cyc();
        end

        // Fixed priority: port 0 always wins, port 1 starves.
        fp.d0 = 32'h0000_0F00; fp.sa0 = 5'd4; fp.right0 = 1'b1;
        fp.d1 = 32'h0000_0F00; fp.sa1 = 5'd4; fp.right1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fp.req0 = (i < 4);
            fp.req1 = (i < 4);
            #1;
            if (i < 4) begin
                chk($sformatf("fp_ack0_%0d", i), 32'(fp.ack0), 1);
                chk($sformatf("fp_ack1_%0d", i), 32'(fp.ack1), 0);
            end
            if (i >= 2) begin
                chk($sformatf("fp_id%0d", i - 2),  32'(fp.res_id), 0);
                chk($sformatf("fp_res%0d", i - 2), fp.res, 32'h0000_00F0);
            end
            cyc();
        end

        // Backpressure: exactly two accepts, output held, then in-order drain.
        rr.res_ready = 1'b0;
        rr.req0 = 1'b1; rr.sa0 = 5'd0; rr.right0 = 1'b0; rr.arith0 = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            rr.d0 = 32'hA0A0_0000 + k;
            #1;
            chk($sformatf("bp_ack%0d", i), 32'(rr.ack0), 32'(i < 2));
            if (i >= 2) begin
                chk($sformatf("bp_val%0d", i), 32'(rr.res_valid), 1);
                chk($sformatf("bp_res%0d", i), rr.res, 32'hA0A0_0000);
            end
            if (rr.ack0) k++;
            cyc();
        end
        rr.req0 = 1'b0;
        rr.res_ready = 1'b1;
        #1;
        chk("bp_drain0", rr.res, 32'hA0A0_0000);
        cyc();
        #1;
        chk("bp_val1",   32'(rr.res_valid), 1);
        chk("bp_drain1", rr.res, 32'hA0A0_0001);
        cyc();
        #1;
        chk("bp_empty", 32'(rr.res_valid), 0);

        // Reset with both stages full; last = 0 going in.
        rr.res_ready = 1'b0;
        rr.req0 = 1'b1; rr.d0 = 32'h5555_0000;
        cyc();
        rr.d0 = 32'h5555_0001;
        cyc();
        rr.req0 = 1'b0;
        #1;
        chk("mr_full", 32'(rr.res_valid), 1);
        rst = 1'b1;
        rr.req0 = 1'b1;
        #1;
        chk("mr_ack_rst", 32'(rr.ack0), 0);
        cyc();
        rst = 1'b0;
        rr.res_ready = 1'b1;
        rr.req0 = 1'b1; rr.d0 = 32'h0C0C_0C0C;
        rr.req1 = 1'b1; rr.d1 = 32'h0D0D_0D0D; rr.sa1 = 5'd0; rr.right1 = 1'b0;
        #1;
        chk("mr_val", 32'(rr.res_valid), 0);
        chk("mr_res", rr.res, 32'h0);
        chk("mr_ack0", 32'(rr.ack0), 1);
        chk("mr_ack1", 32'(rr.ack1), 0);
        cyc();
        rr.req0 = 1'b0;
        rr.req1 = 1'b0;
        #1;
        chk("mr_nostale", 32'(rr.res_valid), 0);
        cyc();
        #1;
        chk("mr_new_val", 32'(rr.res_valid), 1);
        chk("mr_new_res", rr.res, 32'h0C0C_0C0C);
        chk("mr_new_id",  32'(rr.res_id), 0);
        cyc();
        #1;
        chk("mr_end", 32'(rr.res_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
